fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS processor. Holds the program counter and the instruction register, and runs a request/acknowledge handshake with instruction memory. Presents Opcode, Func and the register and immediate fields to the control unit and datapath for one execute cycle. Consumes PCSrc back from control to choose between PC+4 and the branch target.

---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch_unit_pc_next.sv | 21 ++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, instruction field
// positions and the opcode values the main decoder also uses.
package fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM_W = 16;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC arithmetic: sequential PC, sign-extended word-offset branch target
// and the PCSrc select. All sums wrap modulo 2^32.
module pc_next
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0]  pc_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic             pc_src_i,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic [XLEN-1:0]  pc_branch_o,
    output logic [XLEN-1:0]  pc_next_o
);

    logic [XLEN-1:0] br_off;

    assign br_off      = {{14{imm_i[IMM_W-1]}}, imm_i, 2'b00};
    assign pc_plus4_o  = pc_i + XLEN'(4);
    assign pc_branch_o = pc_plus4_o + br_off;
    assign pc_next_o   = pc_src_i ? pc_branch_o : pc_plus4_o;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and instruction registers, imem req/ack
// handshake with an ack timeout, and PC update at the end of execute.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
)(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        PCSrc,
    input  logic        hold,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [5:0]  Func,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] Imm,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        fetch_err
);

    localparam int unsigned    CNT_W  = 16;
    localparam logic [31:0]    PC_RST = RESET_PC & ~32'd3;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [XLEN-1:0]    pc_nxt;
    logic [XLEN-1:0]    pc_branch_unused;

    assign cnt_inc = cnt_q + CNT_W'(1);

    pc_next u_pc_next (
        .pc_i        (pc_q),
        .imm_i       (Imm),
        .pc_src_i    (PCSrc),
        .pc_plus4_o  (PCPlus4),
        .pc_branch_o (pc_branch_unused),
        .pc_next_o   (pc_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= REQ;
        else       state_q <= state_d;
    end

    // Next-state logic; an ack in the last allowed WAIT cycle still wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:  state_d = WAIT;
            WAIT: begin
                if (imem_ack)                       state_d = EXEC;
                else if (cnt_inc == CNT_W'(TIMEOUT)) state_d = ERR;
            end
            EXEC: if (!hold) state_d = REQ;
            ERR:  state_d = ERR;
            default: state_d = REQ;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            REQ:  cnt_d = '0;
            WAIT: begin
                if (imem_ack) instr_d = imem_rdata;
                else          cnt_d   = cnt_inc;
            end
            EXEC: if (!hold) pc_d = pc_nxt;
            default: ;
        endcase
        valid_d = (state_d == EXEC);
        err_d   = err_q | (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RST;
            instr_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Request is a decode of the state register only
    assign imem_req    = (state_q == REQ) || (state_q == WAIT);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

    assign Opcode = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign Rs     = instr_q[RS_MSB:RS_LSB];
    assign Rt     = instr_q[RT_MSB:RT_LSB];
    assign Rd     = instr_q[RD_MSB:RD_LSB];
    assign Imm    = instr_q[IMM_MSB:IMM_LSB];
    assign Func   = instr_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instance A uses default parameters,
// instance B starts at the top of memory with a short ack timeout.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // instance A
    logic        reset_a, ack_a, pcsrc_a, hold_a;
    logic [31:0] rdata_a;
    logic        req_a, valid_a, err_a;
    logic [31:0] addr_a, instr_a, pc_a, pcp4_a;
    logic [5:0]  opc_a, func_a;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [15:0] imm_a;

    // instance B
    logic        reset_b, ack_b, pcsrc_b, hold_b;
    logic [31:0] rdata_b;
    logic        req_b, valid_b, err_b;
    logic [31:0] addr_b, instr_b, pc_b, pcp4_b;
    logic [5:0]  opc_b, func_b;
    logic [4:0]  rs_b, rt_b, rd_b;
    logic [15:0] imm_b;

    fetch_unit u_dut_a (
        .clk(clk), .reset(reset_a), .imem_req(req_a), .imem_addr(addr_a),
        .imem_rdata(rdata_a), .imem_ack(ack_a), .PCSrc(pcsrc_a), .hold(hold_a),
        .Instr(instr_a), .Opcode(opc_a), .Func(func_a), .Rs(rs_a), .Rt(rt_a),
        .Rd(rd_a), .Imm(imm_a), .PC(pc_a), .PCPlus4(pcp4_a),
        .instr_valid(valid_a), .fetch_err(err_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .imem_req(req_b), .imem_addr(addr_b),
        .imem_rdata(rdata_b), .imem_ack(ack_b), .PCSrc(pcsrc_b), .hold(hold_b),
        .Instr(instr_b), .Opcode(opc_b), .Func(func_b), .Rs(rs_b), .Rt(rt_b),
        .Rd(rd_b), .Imm(imm_b), .PC(pc_b), .PCPlus4(pcp4_b),
        .instr_valid(valid_b), .fetch_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting in REQ on instance A: fetch word with ack after delay WAIT cycles
    task automatic fetch_a(input logic [31:0] word, input int delay, input logic [31:0] exp_pc);
        tick();
        for (int i = 0; i < delay; i++) begin
            chk("addr_wait", addr_a, exp_pc);
            chk("req_wait", 32'(req_a), 32'd1);
            tick();
        end
        chk("addr_ack", addr_a, exp_pc);
        ack_a   = 1'b1;
        rdata_a = word;
        tick();
        ack_a   = 1'b0;
        chk("valid_exec", 32'(valid_a), 32'd1);
        chk("instr_exec", instr_a, word);
    endtask

    // Leave EXEC on instance A with the given branch decision
    task automatic exec_a(input logic take);
        hold_a  = 1'b0;
        pcsrc_a = take;
        tick();
        pcsrc_a = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1; ack_a = 1'b0; pcsrc_a = 1'b0; hold_a = 1'b0; rdata_a = '0;
        reset_b = 1'b1; ack_b = 1'b0; pcsrc_b = 1'b0; hold_b = 1'b0; rdata_b = '0;
        tick();
        tick();

        // reset state
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        reset_a = 1'b0;

        // best case: REQ, WAIT+ack, EXEC in cycle 3
        tick();
        chk("c2_req", 32'(req_a), 32'd1);
        chk("c2_addr", addr_a, 32'h0);
        chk("c2_valid", 32'(valid_a), 32'd0);
        ack_a = 1'b1; rdata_a = 32'h0000_0020;
        tick();
        ack_a = 1'b0;
        chk("c3_valid", 32'(valid_a), 32'd1);
        chk("c3_req", 32'(req_a), 32'd0);
        chk("c3_opcode", 32'(opc_a), 32'h0);
        chk("c3_func", 32'(func_a), 32'h20);
        chk("c3_pcp4", pcp4_a, 32'h4);
        exec_a(1'b0);
        chk("next_addr", addr_a, 32'h4);
        chk("next_valid", 32'(valid_a), 32'd0);

        // PC 4 -> 8
        fetch_a(32'h0000_0020, 0, 32'h4);
        exec_a(1'b0);
        chk("pc_8", pc_a, 32'h8);

        // beq Imm=FFFF at PC 8 -> 8
        fetch_a(32'h1000_FFFF, 0, 32'h8);
        chk("beq_opc", 32'(opc_a), 32'h4);
        chk("beq_imm", 32'(imm_a), 32'hFFFF);
        exec_a(1'b1);
        chk("br_m1", pc_a, 32'h8);

        // beq Imm=3 at PC 8 -> 24
        fetch_a(32'h1000_0003, 0, 32'h8);
        exec_a(1'b1);
        chk("br_p3", pc_a, 32'd24);

        // back to 8: 28 + (-5*4)
        fetch_a(32'h1000_FFFB, 0, 32'd24);
        exec_a(1'b1);
        chk("br_back", pc_a, 32'h8);

        // same branch not taken -> 12
        fetch_a(32'h1000_0003, 0, 32'h8);
        exec_a(1'b0);
        chk("br_nt", pc_a, 32'd12);

        // add $3,$1,$2 with ack after 5 wait cycles, then 3 hold cycles
        fetch_a(32'h0022_1820, 5, 32'd12);
        chk("f_rs", 32'(rs_a), 32'd1);
        chk("f_rt", 32'(rt_a), 32'd2);
        chk("f_rd", 32'(rd_a), 32'd3);
        chk("f_imm", 32'(imm_a), 32'h1820);
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", 32'(valid_a), 32'd1);
            chk("hold_pc", pc_a, 32'd12);
            chk("hold_instr", instr_a, 32'h0022_1820);
            hold_a = (i < 3);
            tick();
        end
        hold_a = 1'b0;
        chk("hold_end_valid", 32'(valid_a), 32'd0);
        chk("hold_end_pc", pc_a, 32'd16);

        // reset in WAIT with simultaneous ack, then ack in the following REQ
        tick();
        chk("rw_req", 32'(req_a), 32'd1);
        reset_a = 1'b1; ack_a = 1'b1; rdata_a = 32'hDEAD_BEEF;
        tick();
        reset_a = 1'b0;
        chk("rw_instr", instr_a, 32'h0);
        chk("rw_pc", pc_a, 32'h0);
        chk("rw_valid", 32'(valid_a), 32'd0);
        tick();
        ack_a = 1'b0;
        chk("rw_req_ignored", 32'(valid_a), 32'd0);
        chk("rw_instr2", instr_a, 32'h0);
        chk("rw_wait_req", 32'(req_a), 32'd1);
        tick();
        chk("rw_still_wait", 32'(valid_a), 32'd0);
        ack_a = 1'b1; rdata_a = 32'h0000_0020;
        tick();
        ack_a = 1'b0;
        chk("rw_refetch", instr_a, 32'h0000_0020);
        chk("rw_refetch_v", 32'(valid_a), 32'd1);

        // instance B: wrap-around from 0xFFFFFFFC
        reset_b = 1'b0;
        chk("b_rst_pc", pc_b, 32'hFFFF_FFFC);
        chk("b_rst_pcp4", pcp4_b, 32'h0);
        tick();
        chk("b_addr", addr_b, 32'hFFFF_FFFC);
        ack_b = 1'b1; rdata_b = 32'h0000_0020;
        tick();
        ack_b = 1'b0;
        chk("b_valid", 32'(valid_b), 32'd1);
        tick();
        chk("b_wrap_addr", addr_b, 32'h0);

        // timeout after 4 ack-less WAIT cycles
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("b_to_err", 32'(err_b), 32'd0);
            chk("b_to_req", 32'(req_b), 32'd1);
            tick();
        end
        chk("b_err", 32'(err_b), 32'd1);
        chk("b_err_req", 32'(req_b), 32'd0);
        chk("b_err_valid", 32'(valid_b), 32'd0);
        ack_b = 1'b1; rdata_b = 32'h1234_5678;
        for (int i = 0; i < 3; i++) tick();
        ack_b = 1'b0;
        chk("b_err_sticky", 32'(err_b), 32'd1);
        chk("b_err_req2", 32'(req_b), 32'd0);
        chk("b_err_instr", instr_b, 32'h0000_0020);
        reset_b = 1'b1;
        tick();
        reset_b = 1'b0;
        chk("b_clr_err", 32'(err_b), 32'd0);
        chk("b_clr_pc", pc_b, 32'hFFFF_FFFC);
        chk("b_clr_instr", instr_b, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
